// File: rtl/circ_window_buf_pkg.sv
// circ_window_buf_pkg
//   Shared constants for the circular window buffer and the downstream
//   four-way index generator: window length, default geometry, and the
//   pointer/count width helpers both stages derive their buses from.
package circ_window_buf_pkg;

  localparam int WIN_LEN   = 4;   // the index generator is hard-wired four-way
  localparam int DEF_SIZE  = 16;
  localparam int DEF_WIDTH = 8;
  localparam int STRIDE_W  = 3;   // enough to encode 0..WIN_LEN plus illegal values

  localparam int PTR_W = $clog2(DEF_SIZE);
  localparam int CNT_W = PTR_W + 1;  // count must reach SIZE itself

  function automatic int ptr_w(input int size);
    return $clog2(size);
  endfunction

  function automatic int cnt_w(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/circ_window_buf_if.sv
// circ_window_buf_if
//   Producer/consumer bundle of the circular window buffer.
//   master : producer + consumer side (drives wr_*, adv_*)
//   slave  : the buffer (drives wr_ready, window, status)
//   Signals: wr_en, wr_data, wr_ready, adv_en, adv_stride, rd_ptr,
//            win_data_flat, win_valid, count, empty, err_stride
interface circ_window_buf_if
  import circ_window_buf_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int WIN   = WIN_LEN
);
  localparam int PW = ptr_w(SIZE);
  localparam int CW = cnt_w(SIZE);

  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_ready;
  logic                 adv_en;
  logic [STRIDE_W-1:0]  adv_stride;
  logic [PW-1:0]        rd_ptr;
  logic [WIN*WIDTH-1:0] win_data_flat;
  logic                 win_valid;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 err_stride;

  modport master (
    output wr_en, wr_data, adv_en, adv_stride,
    input  wr_ready, rd_ptr, win_data_flat, win_valid, count, empty, err_stride
  );

  modport slave (
    input  wr_en, wr_data, adv_en, adv_stride,
    output wr_ready, rd_ptr, win_data_flat, win_valid, count, empty, err_stride
  );

endinterface

// File: rtl/circ_window_buf_wrap_add.sv
// wrap_add
//   Modular pointer adder: y = (a + b) mod SIZE.
//   Ports: a, b (pointer-width operands), y (wrapped sum).
//   Handles non-power-of-two SIZE as well, so it never silently relies on
//   truncation.
module wrap_add
  import circ_window_buf_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic [$clog2(SIZE)-1:0] a,
  input  logic [$clog2(SIZE)-1:0] b,
  output logic [$clog2(SIZE)-1:0] y
);
  localparam int W = ptr_w(SIZE);
  localparam logic [W:0] MODULUS = (W+1)'(SIZE);

  logic [W:0] sum;
  logic [W:0] sum_wrapped;

  assign sum         = {1'b0, a} + {1'b0, b};
  assign sum_wrapped = sum - MODULUS;
  assign y           = (sum >= MODULUS) ? sum_wrapped[W-1:0] : sum[W-1:0];

endmodule

// File: rtl/circ_window_buf.sv
// circ_window_buf
//   Circular buffer presenting a WIN-entry sliding window starting at rd_ptr.
//   The consumer retires 0..WIN entries per advance; an oversize stride is
//   rejected and latched in the sticky err_stride flag.
//   Ports: clk, rst (async, active-high), bus (circ_window_buf_if.slave).
module circ_window_buf
  import circ_window_buf_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int WIN   = WIN_LEN
) (
  input  logic               clk,
  input  logic               rst,
  circ_window_buf_if.slave   bus
);
  localparam int PW = ptr_w(SIZE);
  localparam int CW = cnt_w(SIZE);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [SIZE];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_adv;
  logic [CW-1:0]    count, count_nxt, stride_acc;
  logic [PW-1:0]    stride_ext;
  logic             err_stride;
  logic             wr_ready, win_valid;
  logic             stride_ok, wr_acc, adv_acc, adv_bad;

  // Status derives from the registered count, so wr_ready reflects the
  // pre-edge occupancy and a full buffer refuses writes even while an
  // advance frees space in the same cycle.
  assign wr_ready  = (count < CW'(SIZE));
  assign win_valid = (count >= CW'(WIN));

  assign stride_ok  = (bus.adv_stride <= STRIDE_W'(WIN));
  assign wr_acc     = bus.wr_en && wr_ready;
  assign adv_acc    = bus.adv_en && win_valid && stride_ok;
  assign adv_bad    = bus.adv_en && win_valid && !stride_ok;
  assign stride_acc = adv_acc ? CW'(bus.adv_stride) : '0;
  assign count_nxt  = count + CW'(wr_acc) - stride_acc;
  assign stride_ext = PW'(bus.adv_stride);

  wrap_add #(.SIZE(SIZE)) u_wr_inc (.a(wr_ptr), .b(PTR_ONE),    .y(wr_ptr_nxt));
  wrap_add #(.SIZE(SIZE)) u_rd_adv (.a(rd_ptr), .b(stride_ext), .y(rd_ptr_adv));

  for (genvar i = 0; i < WIN; i++) begin : g_win
    logic [PW-1:0] idx;
    wrap_add #(.SIZE(SIZE)) u_idx (.a(rd_ptr), .b(PW'(i)), .y(idx));
    assign bus.win_data_flat[i*WIDTH +: WIDTH] = mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_stride <= 1'b0;
      for (int k = 0; k < SIZE; k++) mem[k] <= '0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= bus.wr_data;
        wr_ptr      <= wr_ptr_nxt;
      end
      if (adv_acc) rd_ptr <= rd_ptr_adv;
      if (adv_bad) err_stride <= 1'b1;
      count <= count_nxt;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.win_valid  = win_valid;
  assign bus.rd_ptr     = rd_ptr;
  assign bus.count      = count;
  assign bus.empty      = (count == '0);
  assign bus.err_stride = err_stride;

endmodule

// File: tb/tb_circ_window_buf.sv
// tb_circ_window_buf
//   Scoreboard bench: each driven cycle pushes the model's expected post-edge
//   state; the entry is popped and compared one step after the edge.
module tb_circ_window_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  circ_window_buf_if #(.SIZE(16), .WIDTH(8), .WIN(4)) bus ();

  circ_window_buf #(.SIZE(16), .WIDTH(8), .WIN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  cnt;
    logic [3:0]  rd;
    logic [31:0] win;
    logic        vld;
    logic        rdy;
    logic        err;
    logic        emp;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [16];
  int         m_wr, m_rd, m_cnt;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_err = 1'b0;
    sbq.delete();
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.cnt = 5'(m_cnt);
    e.rd  = 4'(m_rd);
    for (int i = 0; i < 4; i++) e.win[i*8 +: 8] = m_mem[(m_rd + i) % 16];
    e.vld = (m_cnt >= 4);
    e.rdy = (m_cnt < 16);
    e.err = m_err;
    e.emp = (m_cnt == 0);
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cnt"}, 32'(bus.count), 32'd0);
    chk({tag, "_rd"},  32'(bus.rd_ptr), 32'd0);
    chk({tag, "_emp"}, 32'(bus.empty), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.wr_ready), 32'd1);
    chk({tag, "_vld"}, 32'(bus.win_valid), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_stride), 32'd0);
  endtask

  // One clock of stimulus; the model advances from pre-edge state.
  task automatic step(input logic we, input logic [7:0] d, input logic ae, input logic [2:0] st);
    logic wacc, aok, abad;
    exp_t e;
    bus.wr_en = we; bus.wr_data = d; bus.adv_en = ae; bus.adv_stride = st;
    wacc = we && (m_cnt < 16);
    aok  = ae && (m_cnt >= 4) && (st <= 3'd4);
    abad = ae && (m_cnt >= 4) && (st > 3'd4);
    if (wacc) begin
      m_mem[m_wr] = d;
      m_wr = (m_wr + 1) % 16;
    end
    if (aok) m_rd = (m_rd + int'(st)) % 16;
    if (abad) m_err = 1'b1;
    m_cnt = m_cnt + (wacc ? 1 : 0) - (aok ? int'(st) : 0);
    sbq.push_back(model_snapshot());
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_cnt", 32'(bus.count), 32'(e.cnt));
    chk("sb_rd",  32'(bus.rd_ptr), 32'(e.rd));
    chk("sb_vld", 32'(bus.win_valid), 32'(e.vld));
    chk("sb_rdy", 32'(bus.wr_ready), 32'(e.rdy));
    chk("sb_err", 32'(bus.err_stride), 32'(e.err));
    chk("sb_emp", 32'(bus.empty), 32'(e.emp));
    if (e.vld) chk("sb_win", bus.win_data_flat, e.win);
    bus.wr_en = 1'b0; bus.adv_en = 1'b0; bus.adv_stride = 3'd0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.adv_en = 1'b0; bus.adv_stride = 3'd0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four writes open the first window.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 3'd0);
    chk("w4_vld", 32'(bus.win_valid), 32'd1);
    chk("w4_cnt", 32'(bus.count), 32'd4);
    chk("w4_rd",  32'(bus.rd_ptr), 32'd0);
    chk("w4_win", bus.win_data_flat, 32'h14131211);

    // Fill to SIZE; wr_ptr wraps back to 0.
    for (int i = 4; i < 16; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 3'd0);
    chk("full_rdy", 32'(bus.wr_ready), 32'd0);
    chk("full_cnt", 32'(bus.count), 32'd16);
    step(1'b1, 8'hAA, 1'b0, 3'd0);
    chk("drop_cnt", 32'(bus.count), 32'd16);

    // Write refused on full even though the advance frees two entries.
    step(1'b1, 8'hBB, 1'b1, 3'd2);
    chk("wa_cnt", 32'(bus.count), 32'd14);
    chk("wa_rd",  32'(bus.rd_ptr), 32'd2);
    chk("wa_win", bus.win_data_flat, 32'h16151413);

    // Walk rd_ptr to 14; then advances with win_valid low must be ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 3'd4);
    chk("r14_rd", 32'(bus.rd_ptr), 32'd14);
    step(1'b0, 8'h00, 1'b1, 3'd2);
    step(1'b0, 8'h00, 1'b1, 3'd7);
    chk("ign_err", 32'(bus.err_stride), 32'd0);
    chk("ign_rd",  32'(bus.rd_ptr), 32'd14);

    // count=6 at rd_ptr=14; stride 3 wraps rd_ptr to 1 with a concurrent write.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 3'd0);
    chk("c6_cnt", 32'(bus.count), 32'd6);
    step(1'b1, 8'h35, 1'b1, 3'd3);
    chk("wrap_rd",  32'(bus.rd_ptr), 32'd1);
    chk("wrap_cnt", 32'(bus.count), 32'd4);
    chk("wrap_win", bus.win_data_flat, 32'h35343332);

    // Zero stride is an accepted no-op.
    step(1'b0, 8'h00, 1'b1, 3'd0);
    chk("z_rd", 32'(bus.rd_ptr), 32'd1);

    // Illegal stride: no movement, sticky error.
    step(1'b0, 8'h00, 1'b1, 3'd5);
    chk("bad_err", 32'(bus.err_stride), 32'd1);
    chk("bad_rd",  32'(bus.rd_ptr), 32'd1);
    chk("bad_cnt", 32'(bus.count), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 3'(i));
    chk("hold_err", 32'(bus.err_stride), 32'd1);

    // A few random cycles through the scoreboard.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 4)));

    // Asynchronous reset between edges.
    step(1'b1, 8'h77, 1'b0, 3'd0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    chk("async_win", bus.win_data_flat, 32'h00000000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h51 + i), 1'b0, 3'd0);
    chk("post_win", bus.win_data_flat, 32'h54535251);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
